// File: rtl/alu_result_display.sv
// Result display stage for the 4-bit ALU: captures result/op-code, converts the
// result to BCD by double-dabble (one bit per clock) and scans four 7-segment digits.
module alu_result_display #(
    parameter int unsigned REFRESH_BITS = 18,
    parameter bit          BLANK_ZEROS  = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] result,
    input  logic [3:0] operations,
    input  logic       load,
    output logic       busy,
    output logic [6:0] seg,
    output logic       dp,
    output logic [3:0] an
);

    typedef enum logic {IDLE, CONV} state_t;

    state_t                  state;
    logic [REFRESH_BITS-1:0] scan_cnt;
    logic [7:0]              shift;
    logic [9:0]              bcd;
    logic [2:0]              bitcnt;
    logic [3:0]              code;
    logic [1:0]              disp_h;
    logic [3:0]              disp_t;
    logic [3:0]              disp_o;
    logic [3:0]              disp_code;

    logic [9:0]  bcd_adj;
    logic [17:0] dabble;
    logic        conv_done;
    logic [1:0]  nxt_h;
    logic [3:0]  nxt_t;
    logic [3:0]  nxt_o;
    logic [3:0]  nxt_code;
    logic [1:0]  sel;
    logic [3:0]  nib;
    logic        blank;
    logic [3:0]  an_nxt;
    logic [6:0]  seg_nxt;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    // One double-dabble step: add 3 to nibbles >= 5, then shift {bcd, shift} left.
    always_comb begin
        bcd_adj = bcd;
        if (bcd[3:0] >= 4'd5) bcd_adj[3:0] = bcd[3:0] + 4'd3;
        if (bcd[7:4] >= 4'd5) bcd_adj[7:4] = bcd[7:4] + 4'd3;
        dabble = {bcd_adj, shift} << 1;
    end

    // Digits about to be latched; the segment register uses these so a finished
    // conversion is visible from the very edge the display registers update.
    always_comb begin
        conv_done = (state == CONV) && (bitcnt == 3'd7);
        nxt_h     = conv_done ? dabble[17:16] : disp_h;
        nxt_t     = conv_done ? dabble[15:12] : disp_t;
        nxt_o     = conv_done ? dabble[11:8]  : disp_o;
        nxt_code  = conv_done ? code          : disp_code;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            busy      <= 1'b0;
            shift     <= '0;
            bcd       <= '0;
            bitcnt    <= '0;
            code      <= '0;
            disp_h    <= '0;
            disp_t    <= '0;
            disp_o    <= '0;
            disp_code <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (load) begin
                        shift  <= result;
                        code   <= operations;
                        bcd    <= '0;
                        bitcnt <= '0;
                        busy   <= 1'b1;
                        state  <= CONV;
                    end
                end
                CONV: begin
                    bcd    <= dabble[17:8];
                    shift  <= dabble[7:0];
                    bitcnt <= bitcnt + 3'd1;
                    if (conv_done) begin
                        disp_h    <= nxt_h;
                        disp_t    <= nxt_t;
                        disp_o    <= nxt_o;
                        disp_code <= nxt_code;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign sel = scan_cnt[REFRESH_BITS-1 -: 2];

    always_comb begin
        an_nxt = 4'b0111;
        nib    = nxt_code;
        blank  = 1'b0;
        case (sel)
            2'd0: begin
                an_nxt = 4'b0111;
                nib    = nxt_code;
            end
            2'd1: begin
                an_nxt = 4'b1011;
                nib    = {2'b00, nxt_h};
                blank  = BLANK_ZEROS && (nxt_h == 2'd0);
            end
            2'd2: begin
                an_nxt = 4'b1101;
                nib    = nxt_t;
                blank  = BLANK_ZEROS && (nxt_h == 2'd0) && (nxt_t == 4'd0);
            end
            default: begin
                an_nxt = 4'b1110;
                nib    = nxt_o;
            end
        endcase
        seg_nxt = blank ? 7'b1111111 : hex7(nib);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_cnt <= '0;
            seg      <= '1;
            dp       <= 1'b1;
            an       <= '1;
        end else begin
            scan_cnt <= scan_cnt + 1'b1;
            seg      <= seg_nxt;
            an       <= an_nxt;
            dp       <= (sel != 2'd0);
        end
    end

endmodule

// File: tb/tb_alu_result_display.sv
// Directed bench for alu_result_display: two instances (blanking on/off) share stimulus.
`timescale 1ns/1ps
module tb_alu_result_display;

    localparam logic [6:0] S0  = 7'b1000000;
    localparam logic [6:0] S1  = 7'b1111001;
    localparam logic [6:0] S2  = 7'b0100100;
    localparam logic [6:0] S3  = 7'b0110000;
    localparam logic [6:0] S4  = 7'b0011001;
    localparam logic [6:0] S5  = 7'b0010010;
    localparam logic [6:0] S7  = 7'b1111000;
    localparam logic [6:0] S9  = 7'b0010000;
    localparam logic [6:0] SF  = 7'b0001110;
    localparam logic [6:0] BLK = 7'b1111111;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] result;
    logic [3:0] operations;
    logic       load;
    logic       busy_a, dp_a, busy_b, dp_b;
    logic [6:0] seg_a, seg_b;
    logic [3:0] an_a, an_b;

    int checks = 0;
    int errors = 0;
    int edges;

    always #5 clk = ~clk;

    alu_result_display #(.REFRESH_BITS(4), .BLANK_ZEROS(1'b1)) dut_a (
        .clk(clk), .rst_n(rst_n), .result(result), .operations(operations), .load(load),
        .busy(busy_a), .seg(seg_a), .dp(dp_a), .an(an_a)
    );

    alu_result_display #(.REFRESH_BITS(4), .BLANK_ZEROS(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n), .result(result), .operations(operations), .load(load),
        .busy(busy_b), .seg(seg_b), .dp(dp_b), .an(an_b)
    );

    // Edges since reset release; the scan position follows directly from it.
    always @(posedge clk or negedge rst_n)
        if (!rst_n) edges <= 0;
        else        edges <= edges + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic expect_display(input string tag, input int n,
                                  input logic [6:0] c, input logic [6:0] h,
                                  input logic [6:0] t, input logic [6:0] o,
                                  input logic [6:0] hb, input logic [6:0] tb);
        for (int i = 0; i < n; i++) begin
            int d;
            logic [3:0] ea;
            logic [6:0] es, esb;
            d = ((edges - 1) / 4) % 4;
            case (d)
                0:       begin ea = 4'b0111; es = c; esb = c;  end
                1:       begin ea = 4'b1011; es = h; esb = hb; end
                2:       begin ea = 4'b1101; es = t; esb = tb; end
                default: begin ea = 4'b1110; es = o; esb = o;  end
            endcase
            check({tag, " an"}, an_a, ea);
            check({tag, " an_b"}, an_b, ea);
            check({tag, " dp"}, dp_a, (d != 0));
            check({tag, " seg"}, seg_a, es);
            check({tag, " seg_b"}, seg_b, esb);
            @(negedge clk);
        end
    endtask

    task automatic do_load(input logic [7:0] r, input logic [3:0] op);
        result     = r;
        operations = op;
        load       = 1'b1;
        @(negedge clk);
        load       = 1'b0;
    endtask

    task automatic wait_busy(input string tag);
        int n = 0;
        while (busy_a && n < 20) begin
            n++;
            @(negedge clk);
        end
        check({tag, " busy cycles"}, n, 8);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; load = 1'b0; result = '0; operations = '0;
        repeat (2) @(negedge clk);
        check("reset busy", busy_a, 0);
        check("reset seg", seg_a, BLK);
        check("reset dp", dp_a, 1);
        check("reset an", an_a, 4'b1111);
        rst_n = 1'b1;
        @(negedge clk);
        expect_display("reset scan", 64, S0, BLK, BLK, S0, S0, S0);

        do_load(8'd225, 4'h3);
        wait_busy("225");
        expect_display("225", 16, S3, S2, S2, S5, S2, S2);

        do_load(8'd7, 4'h1);
        wait_busy("7");
        expect_display("7", 16, S1, BLK, BLK, S7, S0, S0);

        // 255, a load two cycles in, and a load on the edge busy falls: both dropped
        do_load(8'd255, 4'hF);
        @(negedge clk);
        do_load(8'd9, 4'h5);
        repeat (5) @(negedge clk);
        check("255 busy before end", busy_a, 1);
        result = 8'd100; operations = 4'hA; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        check("255 busy after end", busy_a, 0);
        expect_display("255", 16, SF, S2, S5, S5, S2, S5);

        do_load(8'd9, 4'h5);
        wait_busy("9");
        expect_display("9", 16, S5, BLK, BLK, S9, S0, S0);

        do_load(8'hFE, 4'h2);
        wait_busy("254");
        expect_display("254", 16, S2, S2, S5, S4, S2, S5);

        do_load(8'd200, 4'h6);
        repeat (3) @(negedge clk);
        check("200 busy mid", busy_a, 1);
        rst_n = 1'b0;
        #1;
        check("abort busy", busy_a, 0);
        check("abort an", an_a, 4'b1111);
        check("abort seg", seg_a, BLK);
        check("abort dp", dp_a, 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post abort busy", busy_a, 0);
        expect_display("post abort", 16, S0, BLK, BLK, S0, S0, S0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
